// File: rtl/point_accum_writer_pkg.sv
// Shared widths, FSM state type and the helpers used by the pointwise accumulate writer.
package point_accum_writer_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 16;
  localparam int LANES      = 8;
  localparam int SIZE_BITS  = 5;
  localparam int OCG_BITS   = 3;

  localparam int ADDR_BITS  = 2 * SIZE_BITS + OCG_BITS;
  localparam int BEAT_WIDTH = LANES * DATA_WIDTH;
  localparam int WORD_WIDTH = LANES * ACC_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, FULL} state_t;

  // Upper h/w/oc bits beyond the address fields are dropped on purpose.
  function automatic logic [ADDR_BITS-1:0] make_addr(input logic [7:0] h,
                                                     input logic [7:0] w,
                                                     input logic [7:0] oc);
    return {h[SIZE_BITS-1:0], w[SIZE_BITS-1:0], oc[OCG_BITS+2:3]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_lane(input logic signed [ACC_WIDTH-1:0] acc,
                                                     input logic relu);
    logic [DATA_WIDTH-1:0] r;
    if (relu && acc[ACC_WIDTH-1])  r = '0;
    else if (acc > SAT_MAX)        r = SAT_MAX[DATA_WIDTH-1:0];
    else if (acc < SAT_MIN)        r = SAT_MIN[DATA_WIDTH-1:0];
    else                           r = acc[DATA_WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/point_accum_writer_ram.sv
// Frame store: one write port, one read port for read-modify-write, one gated readout port.
module accum_lane_ram #(
  parameter int WIDTH     = 128,
  parameter int ADDR_BITS = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr_a,
  output logic [WIDTH-1:0]     rdata_a,
  input  logic                 re_b,
  input  logic [ADDR_BITS-1:0] raddr_b,
  output logic [WIDTH-1:0]     rdata_b
);

  logic [WIDTH-1:0] mem [0:(1 << ADDR_BITS) - 1];

  // NOTE: the array is never reset; only the readout register is, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_a <= mem[raddr_a];
  end

  always_ff @(posedge clk) begin
    if (rst)       rdata_b <= '0;
    else if (re_b) rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/point_accum_writer.sv
// Accumulates 8-lane pointwise partials per (h, w, oc group) and serves the finished frame saturated.
module point_accum_writer
  import point_accum_writer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_h,
  input  logic [7:0]            in_w,
  input  logic [7:0]            in_ic_sel,
  input  logic [7:0]            in_oc_sel,
  input  logic [BEAT_WIDTH-1:0] in_data,
  input  logic                  in_frame_done,
  input  logic                  relu_en,
  input  logic                  rd_en,
  input  logic [7:0]            rd_h,
  input  logic [7:0]            rd_w,
  input  logic [7:0]            rd_oc_sel,
  output logic [BEAT_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  frame_ready,
  input  logic                  frame_release,
  output logic                  busy,
  output logic                  overflow_err
);

  state_t                 state, state_next;
  logic                   accept, rd_fire, ram_we, rd_relu;
  logic [ADDR_BITS-1:0]   in_addr, rd_addr, s1_addr, s2_addr;
  logic [BEAT_WIDTH-1:0]  s1_data;
  logic                   s1_valid, s1_ic_zero, s1_byp, s2_valid;
  logic [WORD_WIDTH-1:0]  s1_byp_data, s1_old, s1_sum, s2_sum, ram_a, ram_b;

  assign in_addr     = make_addr(in_h, in_w, in_oc_sel);
  assign rd_addr     = make_addr(rd_h, rd_w, rd_oc_sel);
  assign accept      = in_valid && (state != FULL);
  assign rd_fire     = rd_en && (state == FULL);
  assign ram_we      = s2_valid && !rst;
  assign frame_ready = (state == FULL);
  assign busy        = (state != IDLE);

  accum_lane_ram #(.WIDTH(WORD_WIDTH), .ADDR_BITS(ADDR_BITS)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .waddr   (s2_addr),
    .wdata   (s2_sum),
    .raddr_a (in_addr),
    .rdata_a (ram_a),
    .re_b    (rd_fire),
    .raddr_b (rd_addr),
    .rdata_b (ram_b)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    s1_old = ram_a;
    if (s1_byp) s1_old = s1_byp_data;
    // The beat ahead in S2 is newer than anything memory or the bypass register holds.
    if (s2_valid && (s2_addr == s1_addr)) s1_old = s2_sum;
    s1_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_sum[i*ACC_WIDTH +: ACC_WIDTH] =
        (s1_ic_zero ? '0 : s1_old[i*ACC_WIDTH +: ACC_WIDTH]) +
        {{(ACC_WIDTH - DATA_WIDTH){s1_data[i*DATA_WIDTH + DATA_WIDTH - 1]}},
         s1_data[i*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)                  state_next = FILL;
      FILL:    if (in_frame_done)             state_next = DRAIN;
      DRAIN:   if (!s1_valid && !in_valid)    state_next = FULL;
      FULL:    if (frame_release)             state_next = IDLE;
      default:                                state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      overflow_err <= 1'b0;
      rd_valid     <= 1'b0;
      rd_relu      <= 1'b0;
    end else begin
      state    <= state_next;
      s1_valid <= accept;
      s2_valid <= s1_valid;
      rd_valid <= rd_fire;
      if (in_valid && (state == FULL)) overflow_err <= 1'b1;
      if (rd_fire) rd_relu <= relu_en;
    end
  end

  // Datapath registers are qualified by the valids above and need no reset.
  always_ff @(posedge clk) begin
    s1_addr     <= in_addr;
    s1_data     <= in_data;
    s1_ic_zero  <= (in_ic_sel == 8'd0);
    s1_byp      <= ram_we && (s2_addr == in_addr);
    s1_byp_data <= s2_sum;
    s2_addr     <= s1_addr;
    s2_sum      <= s1_sum;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < LANES; i++)
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = sat_lane(ram_b[i*ACC_WIDTH +: ACC_WIDTH], rd_relu);
  end

endmodule

// File: tb/tb_point_accum_writer.sv
// Directed bench for point_accum_writer: accumulation, forwarding, saturation, handshake and reset.
module tb_point_accum_writer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_frame_done, relu_en, rd_en, frame_release;
  logic [7:0]  in_h, in_w, in_ic_sel, in_oc_sel, rd_h, rd_w, rd_oc_sel;
  logic [63:0] in_data, rd_data;
  logic        rd_valid, frame_ready, busy, overflow_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  point_accum_writer dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_h          (in_h),
    .in_w          (in_w),
    .in_ic_sel     (in_ic_sel),
    .in_oc_sel     (in_oc_sel),
    .in_data       (in_data),
    .in_frame_done (in_frame_done),
    .relu_en       (relu_en),
    .rd_en         (rd_en),
    .rd_h          (rd_h),
    .rd_w          (rd_w),
    .rd_oc_sel     (rd_oc_sel),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .frame_ready   (frame_ready),
    .frame_release (frame_release),
    .busy          (busy),
    .overflow_err  (overflow_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] h, input logic [7:0] w, input logic [7:0] ic,
                      input logic [7:0] oc, input logic [63:0] d);
    in_valid = 1'b1; in_h = h; in_w = w; in_ic_sel = ic; in_oc_sel = oc; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int n;
    in_frame_done = 1'b1;
    tick();
    in_frame_done = 1'b0;
    n = 0;
    while (!frame_ready && n < 8) begin
      tick();
      n++;
    end
    check(tag, {63'd0, frame_ready && (n <= 2)}, 64'd1);
  endtask

  task automatic read(input string tag, input logic [7:0] h, input logic [7:0] w,
                      input logic [7:0] oc, input logic relu, input logic [63:0] exp);
    rd_en = 1'b1; rd_h = h; rd_w = w; rd_oc_sel = oc; relu_en = relu;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, {63'd0, rd_valid}, 64'd1);
    check(tag, rd_data, exp);
  endtask

  task automatic release_frame();
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_frame_done = 1'b0; relu_en = 1'b0; rd_en = 1'b0;
    frame_release = 1'b0; in_h = '0; in_w = '0; in_ic_sel = '0; in_oc_sel = '0;
    in_data = '0; rd_h = '0; rd_w = '0; rd_oc_sel = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_ready",    {63'd0, frame_ready}, 64'd0);
    check("rst_busy",     {63'd0, busy}, 64'd0);
    check("rst_ovf",      {63'd0, overflow_err}, 64'd0);
    check("rst_rd_data",  rd_data, 64'd0);

    // Frame A: simple accumulate with a gap, 4-deep back-to-back forwarding, write/read collision.
    send(8'd0, 8'd0, 8'd0, 8'd0, 64'h14);
    check("busy_fill", {63'd0, busy}, 64'd1);
    rd_en = 1'b1; rd_h = 8'd0; rd_w = 8'd0; rd_oc_sel = 8'd0;
    tick();
    rd_en = 1'b0;
    check("fill_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("fill_rd_hold",  rd_data, 64'd0);
    send(8'd0, 8'd0, 8'd8, 8'd0, 64'hFB);
    send(8'd1, 8'd2, 8'd0,  8'd8, 64'h0A00_0000);
    send(8'd1, 8'd2, 8'd8,  8'd8, 64'h0A00_0000);
    send(8'd1, 8'd2, 8'd16, 8'd8, 64'h0A00_0000);
    send(8'd1, 8'd2, 8'd24, 8'd8, 64'h0A00_0000);
    send(8'd3, 8'd4, 8'd0, 8'd16, {48'd0, 8'h9C, 8'h64});
    tick();
    send(8'd3, 8'd4, 8'd8, 8'd16, {48'd0, 8'hC4, 8'h32});
    finish_frame("ready_lat_a");

    read("px00",      8'd0, 8'd0, 8'd0,  1'b0, 64'h0F);
    read("fwd_lane3", 8'd1, 8'd2, 8'd8,  1'b0, 64'h2800_0000);
    read("sat",       8'd3, 8'd4, 8'd16, 1'b0, 64'h807F);
    read("sat_relu",  8'd3, 8'd4, 8'd16, 1'b1, 64'h007F);
    read("trunc",     8'h20, 8'h40, 8'h40, 1'b0, 64'h0F);

    // Beat while FULL is dropped.
    send(8'd0, 8'd0, 8'd0, 8'd0, 64'h63);
    tick(); tick();
    check("ovf_set",   {63'd0, overflow_err}, 64'd1);
    check("ovf_ready", {63'd0, frame_ready}, 64'd1);
    read("ovf_reread", 8'd0, 8'd0, 8'd0, 1'b0, 64'h0F);

    // Read coinciding with release is still served.
    rd_en = 1'b1; rd_h = 8'd1; rd_w = 8'd2; rd_oc_sel = 8'd8; relu_en = 1'b0;
    frame_release = 1'b1;
    tick();
    rd_en = 1'b0; frame_release = 1'b0;
    check("rel_rd_valid", {63'd0, rd_valid}, 64'd1);
    check("rel_rd_data",  rd_data, 64'h2800_0000);
    check("rel_busy",     {63'd0, busy}, 64'd0);
    check("rel_ready",    {63'd0, frame_ready}, 64'd0);

    // Frame B: ic=0 overwrites without any clear.
    send(8'd0, 8'd0, 8'd0, 8'd0, 64'h07);
    finish_frame("ready_lat_b");
    read("overwrite", 8'd0, 8'd0, 8'd0, 1'b0, 64'h07);
    release_frame();

    // Reset with an ic=8 beat in flight: it must never land.
    send(8'd0, 8'd0, 8'd8, 8'd0, 64'h32);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy",  {63'd0, busy}, 64'd0);
    check("mid_rst_ready", {63'd0, frame_ready}, 64'd0);
    check("mid_rst_ovf",   {63'd0, overflow_err}, 64'd0);
    send(8'd5, 8'd5, 8'd0, 8'd0, 64'h03);
    send(8'd5, 8'd5, 8'd8, 8'd0, 64'h04);
    finish_frame("ready_lat_c");
    read("post_rst",   8'd5, 8'd5, 8'd0, 1'b0, 64'h07);
    read("discarded",  8'd0, 8'd0, 8'd0, 1'b0, 64'h07);
    release_frame();
    check("final_busy", {63'd0, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
